// File: rtl/int_mult_sched.sv
// Round-robin scheduler sharing one pipelined multiplier between NUM_REQ requesters; grant to rsp_valid is MULT_LATENCY+2 cycles.
// One outstanding op per requester; a stalled response blocks only its own requester.
module int_mult_sched #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 5
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_a_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_b_i,
  output logic [NUM_REQ-1:0]                rsp_valid_o,
  input  logic [NUM_REQ-1:0]                rsp_ready_i,
  output logic [NUM_REQ*2*DATA_WIDTH-1:0]   rsp_data_o,
  output logic                              mult_issue_o,
  output logic [DATA_WIDTH-1:0]             mult_plier_o,
  output logic [DATA_WIDTH-1:0]             mult_cand_o,
  input  logic [2*DATA_WIDTH-1:0]           mult_result_i,
  output logic                              busy_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int PW  = 2 * DATA_WIDTH;

  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] a_arr, b_arr;

  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0] out_q, out_d;
  logic [NUM_REQ-1:0] eligible, grant_oh, rsp_fire;
  logic               grant_vld;
  logic [IDW-1:0]     grant_id, scan_idx;

  logic                  mult_issue_q;
  logic [DATA_WIDTH-1:0] plier_q, cand_q;
  logic [IDW-1:0]        issue_id_q;

  logic [MULT_LATENCY-1:0]          trk_vld_q, trk_vld_d;
  logic [MULT_LATENCY-1:0][IDW-1:0] trk_id_q, trk_id_d;
  logic                             tail_vld;
  logic [IDW-1:0]                   tail_id;

  logic [NUM_REQ-1:0]          rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0][PW-1:0]  rsp_data_q, rsp_data_d;

  assign a_arr = req_a_i;
  assign b_arr = req_b_i;

  // Scan from the pointer; first eligible requester wins.
  always_comb begin
    eligible  = req_valid_i & ~out_q;
    grant_vld = 1'b0;
    grant_id  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (!grant_vld && eligible[scan_idx]) begin
        grant_vld = 1'b1;
        grant_id  = scan_idx;
      end
    end
    grant_oh = '0;
    if (grant_vld && !rst_i) grant_oh[grant_id] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_vld) begin
      if (grant_id == IDW'(NUM_REQ - 1)) ptr_d = '0;
      else                               ptr_d = grant_id + IDW'(1);
    end
  end

  assign rsp_fire = rsp_valid_q & rsp_ready_i;
  assign out_d    = (out_q & ~rsp_fire) | grant_oh;

  always_comb begin
    trk_vld_d    = '0;
    trk_id_d     = '0;
    trk_vld_d[0] = mult_issue_q;
    trk_id_d[0]  = issue_id_q;
    for (int i = 1; i < MULT_LATENCY; i++) begin
      trk_vld_d[i] = trk_vld_q[i-1];
      trk_id_d[i]  = trk_id_q[i-1];
    end
  end

  assign tail_vld = trk_vld_q[MULT_LATENCY-1];
  assign tail_id  = trk_id_q[MULT_LATENCY-1];

  // A requester's slot is always empty when its result lands, so capture never collides with a pending response.
  always_comb begin
    rsp_valid_d = rsp_valid_q & ~rsp_fire;
    rsp_data_d  = rsp_data_q;
    if (tail_vld) begin
      rsp_valid_d[tail_id] = 1'b1;
      rsp_data_d[tail_id]  = mult_result_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q        <= '0;
      out_q        <= '0;
      mult_issue_q <= 1'b0;
      plier_q      <= '0;
      cand_q       <= '0;
      issue_id_q   <= '0;
      trk_vld_q    <= '0;
      trk_id_q     <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      out_q        <= out_d;
      mult_issue_q <= grant_vld;
      if (grant_vld) begin
        plier_q    <= a_arr[grant_id];
        cand_q     <= b_arr[grant_id];
        issue_id_q <= grant_id;
      end
      trk_vld_q    <= trk_vld_d;
      trk_id_q     <= trk_id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign req_ready_o  = grant_oh;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_data_o   = rsp_data_q;
  assign mult_issue_o = mult_issue_q;
  assign mult_plier_o = plier_q;
  assign mult_cand_o  = cand_q;
  assign busy_o       = |out_q;

endmodule

// File: tb/tb_int_mult_sched.sv
// Randomized and directed bench for int_mult_sched against a transaction-level scheduler model and a behavioural multiplier.
module tb_int_mult_sched;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int L  = 5;

  logic                    clk;
  logic                    rst;
  logic [N-1:0]            req_valid;
  logic [N-1:0]            req_ready;
  logic [N-1:0][DW-1:0]    a_arr, b_arr;
  logic [N-1:0]            rsp_valid;
  logic [N-1:0]            rsp_ready;
  logic [N*2*DW-1:0]       rsp_data;
  logic                    mult_issue;
  logic [DW-1:0]           mult_plier, mult_cand;
  logic [2*DW-1:0]         mult_result;
  logic                    busy;

  int_mult_sched #(.DATA_WIDTH(DW), .NUM_REQ(N), .MULT_LATENCY(L)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(a_arr), .req_b_i(b_arr),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .mult_issue_o(mult_issue), .mult_plier_o(mult_plier), .mult_cand_o(mult_cand),
    .mult_result_i(mult_result), .busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: every granted op yields its product L+2 cycles later on the granting requester's port.
  typedef struct { int cnt; int id; logic [63:0] prod; } pend_t;
  pend_t        pq[$];
  int           m_ptr;
  logic [N-1:0] m_out, m_rspv;
  logic [63:0]  m_rspd [N];
  logic         m_iss;
  logic [31:0]  m_plier, m_cand;

  // Behavioural multiplier: garbage when nothing was issued, so a mistimed capture shows up.
  logic [63:0]  mpipe [L];

  int cyc = 0;
  int last_gid;
  int last_g [N];
  int gcount [N];
  bit chk_gap = 0;

  task automatic m_reset();
    m_ptr = 0; m_out = '0; m_rspv = '0; m_iss = 1'b0; m_plier = '0; m_cand = '0;
    for (int k = 0; k < N; k++) m_rspd[k] = '0;
    pq.delete();
  endtask

  task automatic step();
    int          gid;
    logic [N-1:0] g;
    logic        iss_s;
    logic [63:0] prod_s;
    @(negedge clk);
    gid = -1;
    if (!rst)
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (gid < 0 && req_valid[idx] && !m_out[idx]) gid = idx;
      end
    g = (gid >= 0) ? (N'(1) << gid) : '0;
    check("req_ready", 64'(req_ready), 64'(g));
    check("rsp_valid", 64'(rsp_valid), 64'(m_rspv));
    for (int k = 0; k < N; k++) check("rsp_data", rsp_data[k*64 +: 64], m_rspd[k]);
    check("mult_issue", 64'(mult_issue), 64'(m_iss));
    check("mult_plier", 64'(mult_plier), 64'(m_plier));
    check("mult_cand", 64'(mult_cand), 64'(m_cand));
    check("busy", 64'(busy), 64'(|m_out));
    iss_s  = mult_issue;
    prod_s = {32'b0, mult_plier} * {32'b0, mult_cand};
    @(posedge clk);
    last_gid = gid;
    if (!rst) begin
      for (int k = 0; k < N; k++)
        if (m_rspv[k] && rsp_ready[k]) begin
          m_rspv[k] = 1'b0;
          m_out[k]  = 1'b0;
        end
      for (int i = pq.size() - 1; i >= 0; i--) begin
        pq[i].cnt--;
        if (pq[i].cnt == 0) begin
          m_rspv[pq[i].id] = 1'b1;
          m_rspd[pq[i].id] = pq[i].prod;
          pq.delete(i);
        end
      end
      if (gid >= 0) begin
        pend_t p;
        if (chk_gap && last_g[gid] >= 0) check("regrant_gap", 64'(cyc - last_g[gid]), 64'(L + 3));
        last_g[gid] = cyc;
        gcount[gid]++;
        m_out[gid] = 1'b1;
        m_ptr      = (gid + 1) % N;
        m_iss      = 1'b1;
        m_plier    = a_arr[gid];
        m_cand     = b_arr[gid];
        p.cnt = L + 1; p.id = gid; p.prod = {32'b0, a_arr[gid]} * {32'b0, b_arr[gid]};
        pq.push_back(p);
      end else begin
        m_iss = 1'b0;
      end
    end
    for (int i = L - 1; i > 0; i--) mpipe[i] = mpipe[i-1];
    mpipe[0] = iss_s ? prod_s : {$urandom(), $urandom()};
    cyc++;
    #1;
    mult_result = mpipe[L-1];
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    for (int k = 0; k < N; k++) check({tag, "_rsp_data"}, rsp_data[k*64 +: 64], 64'd0);
    check({tag, "_mult_issue"}, 64'(mult_issue), 64'd0);
    check({tag, "_plier_cand"}, {mult_plier, mult_cand}, 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int diff;
    int first_gid;
    rst = 1'b1; req_valid = '0; rsp_ready = '0; a_arr = '0; b_arr = '0; mult_result = '0;
    for (int i = 0; i < L; i++) mpipe[i] = '0;
    for (int k = 0; k < N; k++) begin last_g[k] = -1; gcount[k] = 0; end
    m_reset();
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single request: 7*6 on requester 2
    req_valid = 4'b0100; a_arr[2] = 32'd7; b_arr[2] = 32'd6;
    step();
    check("t1_grant", 64'(last_gid), 64'd2);
    req_valid = '0;
    repeat (6) step();
    check("t1_rsp_valid", 64'(rsp_valid[2]), 64'd1);
    check("t1_rsp_data", rsp_data[2*64 +: 64], 64'd42);
    check("t1_busy", 64'(busy), 64'd1);
    rsp_ready = 4'b0100;
    repeat (3) step();

    // All four continuously valid
    for (int k = 0; k < N; k++) begin a_arr[k] = 32'(k + 1); b_arr[k] = 32'h10; last_g[k] = -1; end
    req_valid = 4'hF; rsp_ready = 4'hF; chk_gap = 1;
    repeat (40) step();
    chk_gap = 0;

    // Backpressure on requester 1
    rsp_ready = 4'b1101;
    repeat (20) step();
    rsp_ready = 4'hF;
    repeat (20) step();

    // Round robin between 0 and 3 starting with ptr = 1
    req_valid = '0;
    repeat (12) step();
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (12) step();
    for (int k = 0; k < N; k++) gcount[k] = 0;
    req_valid = 4'b1001;
    step();
    first_gid = last_gid;
    check("rr_first", 64'(first_gid), 64'd3);
    repeat (99) step();
    diff = gcount[0] - gcount[3];
    if (diff < 0) diff = -diff;
    check("rr_fair", 64'(diff <= 1 && gcount[0] > 5), 64'd1);

    // Reset mid-flight
    req_valid = '0;
    repeat (12) step();
    req_valid = 4'b0001; a_arr[0] = 32'd3; b_arr[0] = 32'd5;
    step();
    req_valid = 4'b0011; a_arr[1] = 32'd9; b_arr[1] = 32'd11;
    step();
    repeat (3) step();
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    m_reset();
    repeat (2) step();
    rst = 1'b0; req_valid = '0;
    repeat (12) step();
    check("midrst_no_rsp", 64'(rsp_valid), 64'd0);

    // Max operands on 1 with neighbours holding data
    req_valid = 4'b0101; a_arr[0] = $urandom(); b_arr[0] = $urandom(); a_arr[2] = $urandom(); b_arr[2] = $urandom();
    step();
    step();
    req_valid = 4'b0010; a_arr[1] = 32'hFFFF_FFFF; b_arr[1] = 32'hFFFF_FFFF;
    step();
    req_valid = '0;
    repeat (10) step();
    check("max_product", rsp_data[1*64 +: 64], 64'hFFFF_FFFE_0000_0001);

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      req_valid = N'($urandom());
      for (int k = 0; k < N; k++) begin
        a_arr[k] = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom();
        b_arr[k] = $urandom();
        rsp_ready[k] = ($urandom_range(0, 3) != 0);
      end
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        m_reset();
      end else begin
        rst = 1'b0;
      end
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/int_mult_sched.md
Name: int_mult_sched

Overview:
- Shares one pipelined integer multiplier (fixed latency, one issue per cycle) between NUM_REQ requesters.
- Each requester gets a valid/ready request port and a valid/ready response port.
- Arbitration is round-robin. Requester IDs are tracked through the pipeline, and each result is returned to the requester that issued it.
- Sits between the ALU front-end issue logic and the multiplier datapath. Allows one outstanding operation per requester.

Parameters:
DATA_WIDTH, 32, operand width; products are 2*DATA_WIDTH
NUM_REQ, 4, number of requesters (2..16)
MULT_LATENCY, 5, cycles from mult_issue sampled to matching mult_result valid (>=1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester grant (one-hot or zero)
req_a  input  NUM_REQ*DATA_WIDTH  multiplier operands, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_b  input  NUM_REQ*DATA_WIDTH  multiplicand operands, same packing
rsp_valid  output  NUM_REQ  per-requester result valid
rsp_ready  input  NUM_REQ  per-requester result accept
rsp_data  output  NUM_REQ*2*DATA_WIDTH  per-requester product, requester i at [i*2*DATA_WIDTH +: 2*DATA_WIDTH]
mult_issue  output  1  operands on mult_plier/mult_cand valid this cycle
mult_plier  output  DATA_WIDTH  operand to multiplier
mult_cand  output  DATA_WIDTH  operand to multiplier
mult_result  input  2*DATA_WIDTH  multiplier product, valid MULT_LATENCY cycles after mult_issue
busy  output  1  OR of outstanding flags

Behaviour:
- Reset (async, rst=1): every output and register is cleared.
  - req_ready, rsp_valid, rsp_data, mult_issue, mult_plier, mult_cand, busy = 0.
  - RR pointer = 0; tracker and outstanding flags cleared.
- Reset mid-operation discards all in-flight work. mult_result values arriving afterwards are ignored, because the tracker is empty.
- outstanding[i] (registered):
  - Set on grant to i.
  - Cleared on rsp_valid[i] & rsp_ready[i].
- eligible = req_valid & ~outstanding.
- Arbitration (combinational):
  - Grant the first eligible index scanning ptr, ptr+1, … modulo NUM_REQ.
  - req_ready = one-hot of the grant; zero if nothing is eligible.
  - req_ready depends on req_valid. Requesters must not make req_valid depend on req_ready.
  - At most one grant per cycle.
  - On a grant to g, ptr <= (g+1) mod NUM_REQ. ptr holds when there is no grant.
- Issue stage (registered): on a grant in cycle t:
  - mult_plier <= req_a[g], mult_cand <= req_b[g], mult_issue <= 1, so mult_issue is high in cycle t+1.
  - With no grant, mult_issue <= 0 and the operands hold their previous values.
- Tracker:
  - A MULT_LATENCY-deep shift register of {valid, id}. It advances every cycle.
  - Entry loaded with {mult_issue, issue_id} in cycle t+1.
  - The tail is valid in cycle t+1+MULT_LATENCY, aligned with mult_result.
- Capture: when the tail is valid with id k:
  - rsp_data[k] <= mult_result; rsp_valid[k] <= 1, so it is visible in cycle t+2+MULT_LATENCY.
  - rsp_valid[k] and rsp_data[k] hold until rsp_ready[k] is sampled high.
  - Then rsp_valid[k] <= 0 and rsp_data[k] holds its last value.
- No capture collision: one outstanding operation per requester guarantees rsp_valid[k]=0 whenever its result arrives.
- Latency:
  - Grant to rsp_valid = MULT_LATENCY+2 cycles.
  - Minimum same-requester turnaround = MULT_LATENCY+3 cycles. The outstanding flag clears at the edge after the response handshake, so a regrant is possible the cycle after.
- Throughput: aggregate one issue per cycle when at least MULT_LATENCY+3 requesters are active. Otherwise it is limited by turnaround.
- Simultaneous response handshake and new req_valid from the same requester: no grant that cycle; eligible the next cycle.
- Response backpressure stalls only that requester. The others continue to be granted.
- Width: the product is unsigned 2*DATA_WIDTH as delivered by the multiplier. The scheduler does no arithmetic on data.

Test Plan:
1. Reset, then single request: req_valid[2]=1, a=7, b=6 -> req_ready[2] the same cycle; mult_issue 1 cycle later with plier=7, cand=6; rsp_valid[2] 7 cycles after grant, rsp_data[2]=42; busy 1 until the handshake.
2. All four requesters valid continuously, rsp_ready=1111 -> grants 0,1,2,3 on consecutive cycles; each requester regranted 8 cycles after its previous grant; results routed to the correct index (a=i+1, b=0x10 gives 0x10, 0x20, 0x30, 0x40).
3. Backpressure: rsp_ready[1]=0 for 20 cycles -> rsp_valid[1] and rsp_data[1] hold; requester 1 is not regranted; requesters 0, 2 and 3 keep cycling; requester 1 is regranted the cycle after rsp_ready[1] is raised.
4. Round-robin fairness: requesters 0 and 3 valid, ptr=1 -> 3 is granted first, then 0. No starvation over 100 cycles; grant counts differ by at most 1.
5. Reset mid-flight: assert rst 3 cycles after grants to 0 and 1 -> all outputs 0 immediately; later mult_result values are ignored; no rsp_valid appears.
6. Max operands: a=b=0xFFFFFFFF -> rsp_data = 0xFFFFFFFE00000001, with no corruption of the neighbouring rsp_data slices.
